alu_issue_ctrl: RTL and testbench

Sequential issue controller that is the initiator for the 32-bit combinational ALU. It accepts one decoded MIPS instruction at a time over a valid/ready request port and derives OP_SELECT, IR (shift amount) and both operands from it. It registers the ALU outputs, maintains the HI/LO registers for MULT/MULTU, and returns the result and branch decision over a valid/ready response port. It sits between the decode stage and the ALU in the datapath.

---
 rtl/alu_issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit combinational ALU: decode, operand/opcode registers, HI/LO and the response.
// Three cycles per op (accept, execute, respond); the response and HI/LO hold steady while rsp_ready is low.
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_opcode,
  input  logic [5:0]       req_funct,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_shamt,
  input  logic [15:0]      req_imm,
  input  logic [WIDTH-1:0] req_rs_data,
  input  logic [WIDTH-1:0] req_rt_data,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_ir,
  output logic [4:0]       alu_op_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_result_hi,
  input  logic             alu_branch_taken,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_branch_taken,
  output logic             rsp_illegal,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic mult;
    logic mfhi;
    logic mflo;
    logic branch;
    logic illegal;
  } kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, dec_kind;
  logic [4:0]       dec_op;
  logic [WIDTH-1:0] dec_in2;
  logic [WIDTH-1:0] imm_sext, imm_zext;
  logic             accept;

  assign imm_sext = {{(WIDTH-16){req_imm[15]}}, req_imm};
  assign imm_zext = {{(WIDTH-16){1'b0}}, req_imm};

  always_comb begin
    dec_op   = 5'b00000;
    dec_in2  = req_rt_data;
    dec_kind = '0;
    case (req_opcode)
      6'b000000: begin
        case (req_funct)
          6'b100001: dec_op = 5'b00000;
          6'b100011: dec_op = 5'b00001;
          6'b011000: begin dec_op = 5'b00010; dec_kind.mult = 1'b1; end
          6'b011001: begin dec_op = 5'b00011; dec_kind.mult = 1'b1; end
          6'b100100: dec_op = 5'b00100;
          6'b100101: dec_op = 5'b00101;
          6'b100110: dec_op = 5'b00110;
          6'b000010: dec_op = 5'b00111;
          6'b000000: dec_op = 5'b01000;
          6'b000011: dec_op = 5'b01001;
          6'b101010: dec_op = 5'b01010;
          6'b101011: dec_op = 5'b01011;
          6'b010000: dec_kind.mfhi = 1'b1;
          6'b010010: dec_kind.mflo = 1'b1;
          default:   dec_kind.illegal = 1'b1;
        endcase
      end
      6'b001001: begin dec_op = 5'b00000; dec_in2 = imm_sext; end
      6'b001100: begin dec_op = 5'b00100; dec_in2 = imm_zext; end
      6'b001101: begin dec_op = 5'b00101; dec_in2 = imm_zext; end
      6'b001110: begin dec_op = 5'b00110; dec_in2 = imm_zext; end
      6'b001010: begin dec_op = 5'b01010; dec_in2 = imm_sext; end
      6'b001011: begin dec_op = 5'b01011; dec_in2 = imm_sext; end
      6'b000100: begin dec_op = 5'b01100; dec_kind.branch = 1'b1; end
      6'b000101: begin dec_op = 5'b01101; dec_kind.branch = 1'b1; end
      6'b000110: begin dec_op = 5'b01110; dec_in2 = '0; dec_kind.branch = 1'b1; end
      6'b000111: begin dec_op = 5'b01111; dec_in2 = '0; dec_kind.branch = 1'b1; end
      6'b000001: begin
        // REGIMM: the rt field selects the compare-against-zero flavour
        dec_in2 = '0;
        if (req_rt == 5'b00000) begin
          dec_op = 5'b10000;
          dec_kind.branch = 1'b1;
        end else if (req_rt == 5'b00001) begin
          dec_op = 5'b10001;
          dec_kind.branch = 1'b1;
        end else begin
          dec_kind.illegal = 1'b1;
        end
      end
      default: dec_kind.illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      kind_q           <= '0;
      alu_input1       <= '0;
      alu_input2       <= '0;
      alu_ir           <= '0;
      alu_op_select    <= '0;
      rsp_result       <= '0;
      rsp_branch_taken <= 1'b0;
      rsp_illegal      <= 1'b0;
      hi_q             <= '0;
      lo_q             <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q <= dec_kind;
        if (dec_kind.illegal) begin
          alu_input1    <= '0;
          alu_input2    <= '0;
          alu_ir        <= '0;
          alu_op_select <= 5'b00000;
        end else begin
          alu_input1    <= req_rs_data;
          alu_input2    <= dec_in2;
          alu_ir        <= req_shamt;
          alu_op_select <= dec_op;
        end
      end
      // ALU outputs are only trusted at the end of EXEC
      if (state_q == EXEC) begin
        rsp_illegal      <= kind_q.illegal;
        rsp_branch_taken <= kind_q.branch & alu_branch_taken;
        if (kind_q.illegal || kind_q.branch) rsp_result <= '0;
        else if (kind_q.mfhi)                rsp_result <= hi_q;
        else if (kind_q.mflo)                rsp_result <= lo_q;
        else                                 rsp_result <= alu_result;
        if (kind_q.mult) begin
          hi_q <= alu_result_hi;
          lo_q <= alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, instruction-level reference model, per-cycle compare.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [5:0]  req_opcode, req_funct;
  logic [4:0]  req_rt, req_shamt;
  logic [15:0] req_imm;
  logic [31:0] req_rs_data, req_rt_data;
  logic [31:0] alu_input1, alu_input2, alu_result, alu_result_hi;
  logic [4:0]  alu_ir, alu_op_select;
  logic        alu_branch_taken;
  logic        rsp_valid, rsp_ready, rsp_branch_taken, rsp_illegal;
  logic [31:0] rsp_result, hi_q, lo_q;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_issue_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_rt(req_rt),
    .req_shamt(req_shamt), .req_imm(req_imm),
    .req_rs_data(req_rs_data), .req_rt_data(req_rt_data),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_ir(alu_ir),
    .alu_op_select(alu_op_select), .alu_result(alu_result),
    .alu_result_hi(alu_result_hi), .alu_branch_taken(alu_branch_taken),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_branch_taken(rsp_branch_taken), .rsp_illegal(rsp_illegal),
    .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  // Combinational ALU; deliberately drives junk on outputs the controller must ignore.
  logic [63:0] prod;
  always_comb begin
    prod             = '0;
    alu_result       = 32'hBAD0_0000 ^ alu_input1;
    alu_result_hi    = ~alu_input2;
    alu_branch_taken = alu_input1[0];
    case (alu_op_select)
      5'd0:  alu_result = alu_input1 + alu_input2;
      5'd1:  alu_result = alu_input1 - alu_input2;
      5'd2:  begin
        prod = $signed({{32{alu_input1[31]}}, alu_input1}) * $signed({{32{alu_input2[31]}}, alu_input2});
        alu_result = prod[31:0]; alu_result_hi = prod[63:32];
      end
      5'd3:  begin
        prod = {32'b0, alu_input1} * {32'b0, alu_input2};
        alu_result = prod[31:0]; alu_result_hi = prod[63:32];
      end
      5'd4:  alu_result = alu_input1 & alu_input2;
      5'd5:  alu_result = alu_input1 | alu_input2;
      5'd6:  alu_result = alu_input1 ^ alu_input2;
      5'd7:  alu_result = alu_input2 >> alu_ir;
      5'd8:  alu_result = alu_input2 << alu_ir;
      5'd9:  alu_result = 32'($signed(alu_input2) >>> alu_ir);
      5'd10: alu_result = 32'($signed(alu_input1) < $signed(alu_input2));
      5'd11: alu_result = 32'(alu_input1 < alu_input2);
      5'd12: alu_branch_taken = (alu_input1 == alu_input2);
      5'd13: alu_branch_taken = (alu_input1 != alu_input2);
      5'd14: alu_branch_taken = alu_input1[31] || (alu_input1 == 32'd0);
      5'd15: alu_branch_taken = !alu_input1[31] && (alu_input1 != 32'd0);
      5'd16: alu_branch_taken = alu_input1[31];
      5'd17: alu_branch_taken = !alu_input1[31];
      default: ;
    endcase
  end

  // Reference model state
  int          m_stage;            // 0 waiting for request, 1 executing, 2 responding
  logic [4:0]  m_op, m_ir;
  logic [31:0] m_in1, m_in2, m_hi, m_lo, m_res;
  logic        m_tk, m_il;
  logic [31:0] p_res, p_nhi, p_nlo;
  logic        p_tk, p_il, p_mult;

  task automatic ref_exec(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] rt,
                          input logic [4:0] sh, input logic [15:0] imm,
                          input logic [31:0] rs, input logic [31:0] rtd);
    int signed   s;
    logic [31:0] se, ze;
    logic [63:0] pr;
    s = rs; se = {{16{imm[15]}}, imm}; ze = {16'b0, imm};
    m_op = 5'd0; m_in1 = rs; m_in2 = rtd; m_ir = sh;
    p_res = 32'd0; p_tk = 1'b0; p_il = 1'b0; p_mult = 1'b0; p_nhi = 32'd0; p_nlo = 32'd0;
    if (opc == 6'h00) begin
      case (fn)
        6'h21: begin m_op = 5'd0;  p_res = rs + rtd; end
        6'h23: begin m_op = 5'd1;  p_res = rs - rtd; end
        6'h18: begin m_op = 5'd2;  pr = 64'($signed(rs) * $signed(rtd));
                     pr = $signed({{32{rs[31]}}, rs}) * $signed({{32{rtd[31]}}, rtd});
                     p_mult = 1'b1; p_nhi = pr[63:32]; p_nlo = pr[31:0]; p_res = pr[31:0]; end
        6'h19: begin m_op = 5'd3;  pr = 64'(rs) * 64'(rtd);
                     p_mult = 1'b1; p_nhi = pr[63:32]; p_nlo = pr[31:0]; p_res = pr[31:0]; end
        6'h24: begin m_op = 5'd4;  p_res = rs & rtd; end
        6'h25: begin m_op = 5'd5;  p_res = rs | rtd; end
        6'h26: begin m_op = 5'd6;  p_res = rs ^ rtd; end
        6'h02: begin m_op = 5'd7;  p_res = rtd >> sh; end
        6'h00: begin m_op = 5'd8;  p_res = rtd << sh; end
        6'h03: begin m_op = 5'd9;  p_res = 32'($signed(rtd) >>> sh); end
        6'h2a: begin m_op = 5'd10; p_res = ($signed(rs) < $signed(rtd)) ? 32'd1 : 32'd0; end
        6'h2b: begin m_op = 5'd11; p_res = (rs < rtd) ? 32'd1 : 32'd0; end
        6'h10: p_res = m_hi;
        6'h12: p_res = m_lo;
        default: p_il = 1'b1;
      endcase
    end else begin
      case (opc)
        6'h09: begin m_op = 5'd0;  m_in2 = se; p_res = rs + se; end
        6'h0c: begin m_op = 5'd4;  m_in2 = ze; p_res = rs & ze; end
        6'h0d: begin m_op = 5'd5;  m_in2 = ze; p_res = rs | ze; end
        6'h0e: begin m_op = 5'd6;  m_in2 = ze; p_res = rs ^ ze; end
        6'h0a: begin m_op = 5'd10; m_in2 = se; p_res = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; end
        6'h0b: begin m_op = 5'd11; m_in2 = se; p_res = (rs < se) ? 32'd1 : 32'd0; end
        6'h04: begin m_op = 5'd12; p_tk = (rs == rtd); end
        6'h05: begin m_op = 5'd13; p_tk = (rs != rtd); end
        6'h06: begin m_op = 5'd14; m_in2 = 32'd0; p_tk = (s <= 0); end
        6'h07: begin m_op = 5'd15; m_in2 = 32'd0; p_tk = (s > 0); end
        6'h01: begin
          m_in2 = 32'd0;
          if (rt == 5'd0)      begin m_op = 5'd16; p_tk = (s < 0); end
          else if (rt == 5'd1) begin m_op = 5'd17; p_tk = (s >= 0); end
          else p_il = 1'b1;
        end
        default: p_il = 1'b1;
      endcase
    end
    if (p_il) begin m_op = 5'd0; m_in1 = 32'd0; m_in2 = 32'd0; m_ir = 5'd0; end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_stage = 0; m_op = '0; m_ir = '0; m_in1 = '0; m_in2 = '0;
      m_hi = '0; m_lo = '0; m_res = '0; m_tk = 1'b0; m_il = 1'b0;
    end else begin
      case (m_stage)
        0: if (req_valid) begin
             ref_exec(req_opcode, req_funct, req_rt, req_shamt, req_imm, req_rs_data, req_rt_data);
             m_stage = 1;
           end
        1: begin
             m_res = p_res; m_tk = p_tk; m_il = p_il;
             if (p_mult) begin m_hi = p_nhi; m_lo = p_nlo; end
             m_stage = 2;
           end
        default: if (rsp_ready) m_stage = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic timeout(input string nm);
    n_cmp++; n_bad++;
    $display("FAIL %s: wait expired at %0t", nm, $time);
    finish_run();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(rst_n && m_stage == 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
      chk("hi_q", hi_q, m_hi);
      chk("lo_q", lo_q, m_lo);
      chk("alu_op_select", 32'(alu_op_select), 32'(m_op));
      chk("alu_input1", alu_input1, m_in1);
      chk("alu_input2", alu_input2, m_in2);
      chk("alu_ir", 32'(alu_ir), 32'(m_ir));
      if (m_stage == 2) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_branch_taken", 32'(rsp_branch_taken), 32'(m_tk));
        chk("rsp_illegal", 32'(rsp_illegal), 32'(m_il));
      end
    end
  end

  logic [31:0] r_res, r_in2;
  logic        r_tk, r_il;
  logic [4:0]  r_op;
  int          r_lat;

  task automatic do_txn(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] rt,
                        input logic [4:0] sh, input logic [15:0] imm,
                        input logic [31:0] rs, input logic [31:0] rtd,
                        input int hold, input bit noise);
    bit acc, got;
    @(posedge clk); #1;
    req_opcode = opc; req_funct = fn; req_rt = rt; req_shamt = sh; req_imm = imm;
    req_rs_data = rs; req_rt_data = rtd; req_valid = 1'b1; rsp_ready = (hold == 0);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
    end
    if (!acc) timeout("accept");
    @(posedge clk); #1;
    req_valid = noise ? 1'($urandom) : 1'b0;
    if (noise) begin
      req_opcode = 6'($urandom); req_funct = 6'($urandom); req_rs_data = $urandom;
    end
    @(negedge clk);
    r_op = alu_op_select; r_in2 = alu_input2; r_lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else begin @(negedge clk); r_lat++; end
    end
    if (!got) timeout("response");
    r_res = rsp_result; r_tk = rsp_branch_taken; r_il = rsp_illegal;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_rsp_result", rsp_result, m_res);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    req_valid = 1'b0;
  endtask

  function automatic logic [11:0] pick(input int k);
    case (k)
      0: pick = {6'h00, 6'h21};  1: pick = {6'h00, 6'h23};  2: pick = {6'h00, 6'h18};
      3: pick = {6'h00, 6'h19};  4: pick = {6'h00, 6'h24};  5: pick = {6'h00, 6'h25};
      6: pick = {6'h00, 6'h26};  7: pick = {6'h00, 6'h02};  8: pick = {6'h00, 6'h00};
      9: pick = {6'h00, 6'h03}; 10: pick = {6'h00, 6'h2a}; 11: pick = {6'h00, 6'h2b};
     12: pick = {6'h00, 6'h10}; 13: pick = {6'h00, 6'h12}; 14: pick = {6'h09, 6'h3f};
     15: pick = {6'h0c, 6'h00}; 16: pick = {6'h0d, 6'h11}; 17: pick = {6'h0e, 6'h22};
     18: pick = {6'h0a, 6'h05}; 19: pick = {6'h0b, 6'h33}; 20: pick = {6'h04, 6'h00};
     21: pick = {6'h05, 6'h01}; 22: pick = {6'h06, 6'h02}; 23: pick = {6'h07, 6'h03};
     24: pick = {6'h01, 6'h00};
      default: pick = {6'($urandom), 6'($urandom)};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_opcode = '0; req_funct = '0; req_rt = '0; req_shamt = '0; req_imm = '0;
    req_rs_data = '0; req_rt_data = '0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_hi", hi_q, 32'd0);
    chk("reset_op", 32'(alu_op_select), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    do_txn(6'h09, 6'h00, 5'd0, 5'd0, 16'hFFFD, 32'd10, 32'd0, 0, 1'b0);
    chk("addiu_op", 32'(r_op), 32'd0);
    chk("addiu_in2", r_in2, 32'hFFFF_FFFD);
    chk("addiu_res", r_res, 32'd7);
    chk("addiu_latency", 32'(r_lat), 32'd2);

    do_txn(6'h00, 6'h19, 5'd0, 5'd0, 16'h0, 32'd65536, 32'd131072, 0, 1'b0);
    chk("multu_hi", hi_q, 32'd2);
    chk("multu_lo", lo_q, 32'd0);
    chk("multu_res", r_res, 32'd0);
    do_txn(6'h00, 6'h10, 5'd0, 5'd0, 16'h0, 32'd77, 32'd88, 0, 1'b0);
    chk("mfhi_res", r_res, 32'd2);
    do_txn(6'h00, 6'h12, 5'd0, 5'd0, 16'h0, 32'd77, 32'd88, 0, 1'b0);
    chk("mflo_res", r_res, 32'd0);

    do_txn(6'h00, 6'h03, 5'd0, 5'd1, 16'h0, 32'd0, 32'hF000_0008, 0, 1'b0);
    chk("sra_res", r_res, 32'hF800_0004);
    chk("sra_hi_kept", hi_q, 32'd2);
    do_txn(6'h00, 6'h02, 5'd0, 5'd4, 16'h0, 32'd0, 32'h0000_000F, 0, 1'b0);
    chk("srl_res", r_res, 32'd0);

    do_txn(6'h07, 6'h00, 5'd0, 5'd0, 16'h0, 32'd5, 32'd0, 0, 1'b0);
    chk("bgtz_taken", 32'(r_tk), 32'd1);
    do_txn(6'h06, 6'h00, 5'd0, 5'd0, 16'h0, 32'd5, 32'd0, 0, 1'b0);
    chk("blez_taken", 32'(r_tk), 32'd0);
    do_txn(6'h04, 6'h00, 5'd0, 5'd0, 16'h0, 32'd9, 32'd9, 0, 1'b0);
    chk("beq_taken", 32'(r_tk), 32'd1);
    chk("beq_res", r_res, 32'd0);
    do_txn(6'h00, 6'h21, 5'd0, 5'd0, 16'h0, 32'd3, 32'd4, 0, 1'b0);
    chk("addu_taken", 32'(r_tk), 32'd0);
    chk("addu_res", r_res, 32'd7);

    do_txn(6'h00, 6'h23, 5'd0, 5'd0, 16'h0, 32'd25, 32'd10, 4, 1'b0);
    chk("subu_res", r_res, 32'd15);
    @(negedge clk);
    chk("subu_release_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("subu_idle_ready", 32'(req_ready), 32'd1);
    chk("subu_idle_valid", 32'(rsp_valid), 32'd0);

    @(posedge clk); #1;
    req_opcode = 6'h00; req_funct = 6'h18; req_rs_data = 32'h1234_5678;
    req_rt_data = 32'h9ABC_DEF0; req_valid = 1'b1;
    @(negedge clk);
    chk("mult_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_hi", hi_q, 32'd0);
    chk("rst_mid_lo", lo_q, 32'd0);
    do_txn(6'h3F, 6'h21, 5'd0, 5'd3, 16'h1234, 32'd11, 32'd22, 0, 1'b0);
    chk("illegal_flag", 32'(r_il), 32'd1);
    chk("illegal_res", r_res, 32'd0);

    for (int t = 0; t < 300; t++) begin
      logic [11:0] oc;
      logic [31:0] rs, rtd;
      int hold;
      oc = pick($urandom_range(0, 27));
      rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
      rtd = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      do_txn(oc[11:6], oc[5:0], 5'($urandom_range(0, 2)), 5'($urandom), 16'($urandom),
             rs, rtd, hold, 1'($urandom));
    end
    @(posedge clk); #1;
    @(negedge clk);
    finish_run();
  end

  initial begin
    #500000;
    timeout("global");
  end

endmodule
